// File: rtl/hpdmc_wrpath16_if.sv
// hpdmc_wrpath16_if: write-buffer handshake and DDR pad-side output bundle
interface hpdmc_wrpath16_if;
   logic        write_start;
   logic        busy;
   logic        cmd_err;
   logic [31:0] dat_i;
   logic [3:0]  sel_i;
   logic        dat_valid;
   logic        dat_ack;
   logic [15:0] dq_q0;
   logic [15:0] dq_q1;
   logic [1:0]  dm_q0;
   logic [1:0]  dm_q1;
   logic        dq_oe;
   logic        dqs_q0;
   logic        dqs_q1;
   logic        dqs_oe;
   logic        underrun;

   modport master (
      output write_start, dat_i, sel_i, dat_valid,
      input  busy, cmd_err, dat_ack, dq_q0, dq_q1, dm_q0, dm_q1,
             dq_oe, dqs_q0, dqs_q1, dqs_oe, underrun
   );

   modport slave (
      input  write_start, dat_i, sel_i, dat_valid,
      output busy, cmd_err, dat_ack, dq_q0, dq_q1, dm_q0, dm_q1,
             dq_oe, dqs_q0, dqs_q1, dqs_oe, underrun
   );
endinterface

// File: rtl/hpdmc_wrpath16.sv
// hpdmc_wrpath16: 16-bit DDR write datapath producing registered DQ/DM/DQS for ODDR2 pads
module hpdmc_wrpath16 #(
   parameter int          BURST_BEATS = 4,
   parameter logic [15:0] IDLE_DQ     = 16'h0000
) (
   input logic             sys_clk,
   input logic             sys_rst,
   hpdmc_wrpath16_if.slave bus
);
   localparam int BW = (BURST_BEATS > 2) ? $clog2(BURST_BEATS) : 1;
   localparam logic [BW-1:0] LAST   = BW'(BURST_BEATS - 1);
   localparam logic [BW-1:0] PENULT = BW'(BURST_BEATS - 2);

   typedef enum logic [1:0] {IDLE, PRE, DATA, POST} state_t;

   state_t        state, state_n;
   logic [BW-1:0] beat, beat_n;
   logic          chain, chain_n;
   logic          err;
   logic          in_data;

   assign in_data     = state_n == DATA;
   assign bus.dat_ack = in_data & bus.dat_valid;
   assign bus.busy    = state != IDLE;
   assign bus.dqs_q1  = 1'b0;

   // Burst sequencing state: phase, beat position and pending chained burst.
   always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) begin
         state <= IDLE;
         beat  <= '0;
         chain <= 1'b0;
      end else begin
         state <= state_n;
         beat  <= beat_n;
         chain <= chain_n;
      end

   // Next phase and command acceptance; a start on the penultimate beat chains seamlessly,
   // one on the last beat reopens with a preamble, and one colliding with a pending chain is refused.
   always_comb begin
      state_n = state;
      beat_n  = '0;
      chain_n = chain;
      err     = 1'b0;
      case (state)
         IDLE, POST: state_n = bus.write_start ? PRE : IDLE;
         PRE: begin
            state_n = DATA;
            err     = bus.write_start;
         end
         DATA:
            if (beat == LAST) begin
               chain_n = 1'b0;
               state_n = chain ? DATA : (bus.write_start ? PRE : POST);
               err     = bus.write_start & chain;
            end else begin
               state_n = DATA;
               beat_n  = beat + 1'b1;
               chain_n = chain | (bus.write_start & (beat == PENULT));
               err     = bus.write_start & (beat != PENULT);
            end
         default: state_n = IDLE;
      endcase
   end

   // Pad-side values are registered from the phase being entered; a starved beat is fully masked.
   always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) begin
         bus.dq_oe    <= 1'b0;
         bus.dqs_oe   <= 1'b0;
         bus.dqs_q0   <= 1'b0;
         bus.dq_q0    <= IDLE_DQ;
         bus.dq_q1    <= IDLE_DQ;
         bus.dm_q0    <= 2'b11;
         bus.dm_q1    <= 2'b11;
         bus.underrun <= 1'b0;
         bus.cmd_err  <= 1'b0;
      end else begin
         bus.dq_oe    <= in_data;
         bus.dqs_oe   <= state_n != IDLE;
         bus.dqs_q0   <= in_data;
         bus.dq_q0    <= bus.dat_ack ? bus.dat_i[31:16] : IDLE_DQ;
         bus.dq_q1    <= bus.dat_ack ? bus.dat_i[15:0] : IDLE_DQ;
         bus.dm_q0    <= bus.dat_ack ? ~bus.sel_i[3:2] : 2'b11;
         bus.dm_q1    <= bus.dat_ack ? ~bus.sel_i[1:0] : 2'b11;
         bus.underrun <= bus.underrun | (in_data & ~bus.dat_valid);
         bus.cmd_err  <= bus.cmd_err | err;
      end
endmodule

// File: tb/tb_hpdmc_wrpath16.sv
// tb_hpdmc_wrpath16: directed and random write bursts checked against a cycle-plan model
module tb_hpdmc_wrpath16;
   localparam int          BB  = 4;
   localparam logic [15:0] IDQ = 16'hDEAD;
   localparam int          N   = 4096;
   localparam int P_IDLE = 0, P_PRE = 1, P_DATA = 2, P_POST = 3;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;

   hpdmc_wrpath16_if bus();

   hpdmc_wrpath16 #(.BURST_BEATS(BB), .IDLE_DQ(IDQ)) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .bus(bus)
   );

   always #5 sys_clk = ~sys_clk;

   // The model plans every future cycle's phase; an accepted command stamps its burst onto the plan.
   int plan [N];
   int pos  [N];
   int c;
   int vectors;
   int miscompares;
   logic [15:0] e_q0, e_q1;
   logic [1:0]  e_m0, e_m1;
   logic        e_err, e_urun;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, got, exp);
      end
   endtask

   function automatic bit accept(int t);
      return plan[t] == P_IDLE || plan[t] == P_POST ||
             (plan[t] == P_DATA && pos[t] == BB - 2) ||
             (plan[t] == P_DATA && pos[t] == BB - 1 && plan[t + 1] != P_DATA);
   endfunction

   task automatic model_idle_outputs();
      e_q0 = IDQ;
      e_q1 = IDQ;
      e_m0 = 2'b11;
      e_m1 = 2'b11;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         plan[i] = P_IDLE;
         pos[i]  = 0;
      end
      model_idle_outputs();
      e_err  = 1'b0;
      e_urun = 1'b0;
   endtask

   task automatic step(input bit ws, input bit valid, input logic [3:0] sel);
      logic [31:0] d;
      bit acc;
      d = $urandom;
      bus.write_start = ws;
      bus.dat_valid   = valid;
      bus.sel_i       = sel;
      bus.dat_i       = d;
      acc = ws && accept(c);
      if (acc) begin
         if (plan[c + 1] != P_DATA) plan[c + 1] = P_PRE;
         for (int k = 0; k < BB; k++) begin
            plan[c + 2 + k] = P_DATA;
            pos[c + 2 + k]  = k;
         end
         plan[c + 2 + BB] = P_POST;
      end
      @(negedge sys_clk);
      chk("busy",     32'(bus.busy),     32'(plan[c] != P_IDLE));
      chk("dq_oe",    32'(bus.dq_oe),    32'(plan[c] == P_DATA));
      chk("dqs_oe",   32'(bus.dqs_oe),   32'(plan[c] != P_IDLE));
      chk("dqs_q0",   32'(bus.dqs_q0),   32'(plan[c] == P_DATA));
      chk("dqs_q1",   32'(bus.dqs_q1),   32'd0);
      chk("dq_q0",    32'(bus.dq_q0),    32'(e_q0));
      chk("dq_q1",    32'(bus.dq_q1),    32'(e_q1));
      chk("dm_q0",    32'(bus.dm_q0),    32'(e_m0));
      chk("dm_q1",    32'(bus.dm_q1),    32'(e_m1));
      chk("cmd_err",  32'(bus.cmd_err),  32'(e_err));
      chk("underrun", 32'(bus.underrun), 32'(e_urun));
      chk("dat_ack",  32'(bus.dat_ack),  32'(plan[c + 1] == P_DATA && valid));
      if (ws && !acc) e_err = 1'b1;
      if (plan[c + 1] == P_DATA && valid) begin
         e_q0 = d[31:16];
         e_q1 = d[15:0];
         e_m0 = ~sel[3:2];
         e_m1 = ~sel[1:0];
      end else begin
         model_idle_outputs();
         if (plan[c + 1] == P_DATA) e_urun = 1'b1;
      end
      @(posedge sys_clk);
      #1;
      c++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 4'hF);
   endtask

   task automatic mid_reset();
      #2;
      sys_rst = 1'b1;
      #1;
      chk("rst_dq_oe",   32'(bus.dq_oe),   32'd0);
      chk("rst_dqs_oe",  32'(bus.dqs_oe),  32'd0);
      chk("rst_busy",    32'(bus.busy),    32'd0);
      chk("rst_dat_ack", 32'(bus.dat_ack), 32'd0);
      chk("rst_dq_q0",   32'(bus.dq_q0),   32'(IDQ));
      chk("rst_dm_q1",   32'(bus.dm_q1),   32'd3);
      chk("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
      chk("rst_urun",    32'(bus.underrun), 32'd0);
      model_reset();
      @(negedge sys_clk);
      sys_rst = 1'b0;
      @(posedge sys_clk);
      #1;
      c++;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      c           = 0;
      bus.write_start = 1'b0;
      bus.dat_valid   = 1'b0;
      bus.sel_i       = 4'h0;
      bus.dat_i       = 32'h0;
      model_reset();
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      @(posedge sys_clk);
      #1;
      idle(2);
      // single burst with byte masking on beat 1
      step(1'b1, 1'b1, 4'hF);
      step(1'b0, 1'b1, 4'hF);
      step(1'b0, 1'b1, 4'b1001);
      step(1'b0, 1'b1, 4'hF);
      step(1'b0, 1'b1, 4'hF);
      idle(5);
      // seamless back-to-back
      step(1'b1, 1'b1, 4'hF);
      idle(3);
      step(1'b1, 1'b1, 4'hF);
      idle(9);
      // one-cycle gap
      step(1'b1, 1'b1, 4'hF);
      idle(4);
      step(1'b1, 1'b1, 4'hF);
      idle(9);
      // starts during PRE and on beat 1 are refused
      step(1'b1, 1'b1, 4'hF);
      step(1'b1, 1'b1, 4'hF);
      step(1'b0, 1'b1, 4'hF);
      step(1'b1, 1'b1, 4'hF);
      idle(6);
      // underrun on beat 2
      step(1'b1, 1'b1, 4'hF);
      step(1'b0, 1'b1, 4'hF);
      step(1'b0, 1'b1, 4'hF);
      step(1'b0, 1'b0, 4'hF);
      idle(6);
      // reset in the middle of a burst, then a clean burst
      step(1'b1, 1'b1, 4'hF);
      step(1'b0, 1'b1, 4'hF);
      step(1'b0, 1'b1, 4'hF);
      mid_reset();
      step(1'b1, 1'b1, 4'h6);
      idle(8);
      // random traffic
      for (int i = 0; i < 1500 && c < N - 16; i++)
         step($urandom_range(0, 4) == 0, $urandom_range(0, 7) != 0, 4'($urandom));
      idle(8);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
